// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing the async FIFO write port among NREQ producers.
// Optional per-requester beat/packet counters are enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int DSIZE = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  win,
  output logic [DSIZE-1:0]      wdata,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]    beat_cnt,
  output logic [NREQ*16-1:0]    pkt_cnt
`endif
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] grant_nxt;
  logic [IDW-1:0] last_grant, last_nxt;
  logic [IDW-1:0] pick, cand;
  logic           found;

  // Round-robin search starting just after the previous owner, wrapping at NREQ.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_grant) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_grant;
    win       = 1'b0;
    req_ready = '0;
    wdata     = req_data[int'(grant_id)*DSIZE +: DSIZE];
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        req_ready[grant_id] = !wfull;
        win                 = req_valid[grant_id] & !wfull;
        if (win && req_last[grant_id]) begin
          state_nxt = IDLE;
          last_nxt  = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (wrst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
    end
  end

  assign busy = (state == LOCK);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0]     beat_q [NREQ];
  logic [15:0]     pkt_q  [NREQ];
  logic [NREQ-1:0] acc;

  assign acc = req_valid & req_ready;

  // Counters saturate rather than wrap so a stuck-high reading is unambiguous.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      for (int i = 0; i < NREQ; i++) begin
        beat_q[i] <= '0;
        pkt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && beat_q[i] != 16'hFFFF) beat_q[i] <= beat_q[i] + 16'd1;
        if (acc[i] && req_last[i] && pkt_q[i] != 16'hFFFF) pkt_q[i] <= pkt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    beat_cnt = '0;
    pkt_cnt  = '0;
    for (int i = 0; i < NREQ; i++) begin
      beat_cnt[i*16 +: 16] = beat_q[i];
      pkt_cnt[i*16 +: 16]  = pkt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues drive beats, expected writes are
// queued in grant order and popped whenever win is seen.
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int IDW   = $clog2(NREQ);

  logic                  wclk;
  logic                  wrst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  win;
  logic [DSIZE-1:0]      wdata;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ*16-1:0]    beat_cnt;
  logic [NREQ*16-1:0]    pkt_cnt;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .win       (win),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .beat_cnt  (beat_cnt),
    .pkt_cnt   (pkt_cnt)
`endif
  );

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [DSIZE-1:0] data;
  } exp_t;

  logic [DSIZE:0]  src_q [NREQ][$];
  exp_t            exp_q [$];
  logic [NREQ-1:0] hold;
  int              n_checks;
  int              n_errors;

  logic            s_busy, s_win;
  logic [NREQ-1:0] s_ready;
  logic [IDW-1:0]  s_gid;

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    logic [NREQ-1:0]       v, l;
    logic [NREQ*DSIZE-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!hold[i] && src_q[i].size() != 0) begin
        v[i]                = 1'b1;
        l[i]                = src_q[i][0][DSIZE];
        d[i*DSIZE +: DSIZE] = src_q[i][0][DSIZE-1:0];
      end
    end
    req_valid = v;
    req_last  = l;
    req_data  = d;
  endtask

  task automatic send(input int id, input logic [DSIZE-1:0] d, input logic last);
    exp_t e;
    src_q[id].push_back({last, d});
    e.id   = IDW'(id);
    e.data = d;
    exp_q.push_back(e);
    drive();
  endtask

  // One clock: sample/score at the falling edge, retire accepted beats just after the rising edge.
  task automatic tick();
    logic [NREQ-1:0] acc;
    exp_t            e;
    @(negedge wclk);
    s_busy  = busy;
    s_win   = win;
    s_ready = req_ready;
    s_gid   = grant_id;
    acc     = req_valid & req_ready;
    check("win_while_full", 32'(win & wfull), 32'd0);
    if (win) begin
      if (exp_q.size() == 0) begin
        check("spurious_win", 32'(win), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_id", 32'(grant_id), 32'(e.id));
        check("wr_data", 32'(wdata), 32'(e.data));
      end
    end
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    hold = '0;
    drive();
  endtask

  task automatic do_reset();
    flush();
    wfull = 1'b0;
    wrst  = 1'b1;
    tick();
    wrst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int wins;
    n_checks = 0;
    n_errors = 0;
    hold     = '0;
    wfull    = 1'b0;
    wrst     = 1'b1;
    drive();

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_win", 32'(s_win), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_gid", 32'(s_gid), 32'd0);
    wrst = 1'b0;

    // 3-beat packet from requester 0
    do_reset();
    send(0, 8'hA1, 1'b0);
    send(0, 8'hA2, 1'b0);
    send(0, 8'hA3, 1'b1);
    tick();
    check("p1_idle_busy", 32'(s_busy), 32'd0);
    check("p1_idle_win", 32'(s_win), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("p1_busy", 32'(s_busy), 32'd1);
      check("p1_win", 32'(s_win), 32'd1);
    end
    tick();
    check("p1_done_busy", 32'(s_busy), 32'd0);
    check("p1_left", 32'(exp_q.size()), 32'd0);

    // All requesters, single-beat packets: round-robin with one bubble
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) send(i, 8'(8'h10 * (r + 1) + i), 1'b1);
    wins = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (s_win) wins++;
      check("rr_bubble", 32'(s_win), 32'(k % 2));
    end
    check("rr_wins", 32'(wins), 32'd8);
    check("rr_left", 32'(exp_q.size()), 32'd0);

    // Requester 2 stalled by wfull mid-packet
    do_reset();
    send(2, 8'hC1, 1'b0);
    send(2, 8'hC2, 1'b0);
    send(2, 8'hC3, 1'b0);
    send(2, 8'hC4, 1'b1);
    tick();
    tick();
    check("full_first_win", 32'(s_win), 32'd1);
    wfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("full_win", 32'(s_win), 32'd0);
      check("full_ready", 32'(s_ready), 32'd0);
      check("full_busy", 32'(s_busy), 32'd1);
    end
    wfull = 1'b0;
    drain(20);
    for (int k = 0; k < 3; k++) tick();

    // Requester 1 stalls its own packet; requester 3 must wait
    do_reset();
    send(1, 8'hB1, 1'b0);
    send(1, 8'hB2, 1'b0);
    send(1, 8'hB3, 1'b1);
    send(3, 8'hD1, 1'b1);
    tick();
    tick();
    check("hold_first_gid", 32'(s_gid), 32'd1);
    hold[1] = 1'b1;
    drive();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hold_win", 32'(s_win), 32'd0);
      check("hold_busy", 32'(s_busy), 32'd1);
      check("hold_gid", 32'(s_gid), 32'd1);
    end
    hold[1] = 1'b0;
    drive();
    drain(20);

    // Reset in the middle of requester 3's packet
    do_reset();
    for (int k = 0; k < 4; k++) send(3, 8'(8'hE1 + k), k == 3);
    tick();
    tick();
    tick();
    check("mid_gid", 32'(s_gid), 32'd3);
    flush();
    wrst = 1'b1;
    tick();
    wrst = 1'b0;
    for (int i = 0; i < NREQ; i++) send(i, 8'(8'hF0 + i), 1'b1);
    tick();
    check("after_rst_busy", 32'(s_busy), 32'd0);
    tick();
    check("after_rst_gid", 32'(s_gid), 32'd0);
    drain(20);

`ifdef FIFO_WR_ARB_STATS_EN
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k++) send(0, 8'(8'h30 + 3 * p + k), k == 2);
    drain(30);
    check("beat_cnt0", 32'(beat_cnt[15:0]), 32'd6);
    check("pkt_cnt0", 32'(pkt_cnt[15:0]), 32'd2);
    check("beat_cnt1", 32'(beat_cnt[31:16]), 32'd0);
    for (int k = 0; k < 65540; k++) send(0, 8'(k), k == 65539);
    drain(70000);
    check("beat_sat", 32'(beat_cnt[15:0]), 32'h0000FFFF);
    check("pkt_cnt0_b", 32'(pkt_cnt[15:0]), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
